// File: rtl/alu_pkg.sv
// Shared ALU op-code constants and the divide sequencer state type.
// Used by the E-stage multi-cycle divider and its testbench.
package alu_pkg;

    localparam logic [4:0] OP_DIV  = 5'd6;
    localparam logic [4:0] OP_DIVU = 5'd7;
    localparam logic [4:0] OP_REM  = 5'd8;
    localparam logic [4:0] OP_REMU = 5'd9;
    localparam int         W_BIT   = 5;
    localparam int         WLEN    = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    function automatic logic isDivOp(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic isSignedOp(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic isRemOp(input logic [4:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring divide step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_iter_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] remIn,
    input  logic [XLEN-1:0] quotIn,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] remOut,
    output logic [XLEN-1:0] quotOut
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in XLEN+1 bits and the top bit of the difference is its sign.
    always_comb begin
        shifted = {remIn, quotIn[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[XLEN]) begin
            remOut  = diff[XLEN-1:0];
            quotOut = {quotIn[XLEN-2:0], 1'b1};
        end else begin
            remOut  = shifted[XLEN-1:0];
            quotOut = {quotIn[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle divide/remainder sequencer for the Execute stage: stalls the
// pipeline while a restoring divider iterates, then presents the result for one cycle.
module div_seq_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enableE,
    input  logic [5:0]      ALUControlE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            StallDivE,
    output logic            DivDoneE,
    output logic [XLEN-1:0] DivResultE
);

    localparam int CW = $clog2(XLEN) + 1;

    function automatic logic [XLEN-1:0] sextW(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

    div_state_t      state, nextState;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] remReg, quotReg, divisorReg, resultReg;
    logic            isWReg, isRemReg, qNegReg, rNegReg;

    logic [4:0]      opCode;
    logic            isW, signedOp, remOp, start;
    logic            signA, signB, divByZero, overflow, special;
    logic [XLEN-1:0] aExt, quotLoad, divisorLoad, specialResult;
    logic [XLEN-1:0] remNext, quotNext;
    logic [XLEN-1:0] qRaw, qSigned, rSigned, selResult, fixResult;
    logic            lastIter;

    // Decode, operand magnitudes and special-case detection at start.
    always_comb begin
        opCode   = ALUControlE[4:0];
        isW      = ALUControlE[W_BIT];
        signedOp = isSignedOp(opCode);
        remOp    = isRemOp(opCode);
        start    = enableE & ~FlushE & isDivOp(opCode);

        signA = signedOp & (isW ? SrcAE[WLEN-1] : SrcAE[XLEN-1]);
        signB = signedOp & (isW ? SrcBE[WLEN-1] : SrcBE[XLEN-1]);

        // W dividends sit in the upper half so the step always consumes the MSB.
        if (isW) begin
            quotLoad    = {(signA ? -SrcAE[WLEN-1:0] : SrcAE[WLEN-1:0]), {(XLEN-WLEN){1'b0}}};
            divisorLoad = {{(XLEN-WLEN){1'b0}}, (signB ? -SrcBE[WLEN-1:0] : SrcBE[WLEN-1:0])};
            aExt        = sextW(SrcAE[WLEN-1:0]);
            divByZero   = (SrcBE[WLEN-1:0] == '0);
            overflow    = signedOp & (SrcAE[WLEN-1:0] == 32'h8000_0000) & (&SrcBE[WLEN-1:0]);
        end else begin
            quotLoad    = signA ? -SrcAE : SrcAE;
            divisorLoad = signB ? -SrcBE : SrcBE;
            aExt        = SrcAE;
            divByZero   = (SrcBE == '0);
            overflow    = signedOp & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&SrcBE);
        end
        special = divByZero | overflow;

        if (remOp) specialResult = divByZero ? aExt : '0;
        else       specialResult = divByZero ? '1 : aExt;
    end

    div_iter_step #(.XLEN(XLEN)) u_step (
        .remIn   (remReg),
        .quotIn  (quotReg),
        .divisor (divisorReg),
        .remOut  (remNext),
        .quotOut (quotNext)
    );

    // Sign correction and quotient/remainder select for the FIX cycle.
    always_comb begin
        qRaw      = isWReg ? {{(XLEN-WLEN){1'b0}}, quotReg[WLEN-1:0]} : quotReg;
        qSigned   = qNegReg ? -qRaw : qRaw;
        rSigned   = rNegReg ? -remReg : remReg;
        selResult = isRemReg ? rSigned : qSigned;
        fixResult = isWReg ? sextW(selResult[WLEN-1:0]) : selResult;
        lastIter  = isWReg ? (count == CW'(WLEN-1)) : (count == CW'(XLEN-1));
    end

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the case can leave a latch behind.
    always_comb begin
        nextState = state;
        StallDivE = 1'b0;
        DivDoneE  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    StallDivE = 1'b1;
                    nextState = special ? DONE : CALC;
                end
            end
            CALC: begin
                StallDivE = 1'b1;
                if (lastIter) nextState = FIX;
            end
            FIX: begin
                StallDivE = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                DivDoneE  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (FlushE) nextState = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only; the datapath
    // registers are cleared on reset too so an aborted op leaves nothing behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            remReg     <= '0;
            quotReg    <= '0;
            divisorReg <= '0;
            resultReg  <= '0;
            isWReg     <= 1'b0;
            isRemReg   <= 1'b0;
            qNegReg    <= 1'b0;
            rNegReg    <= 1'b0;
        end else begin
            state <= nextState;
            count <= (state == CALC) ? count + CW'(1) : '0;

            if (state == IDLE && start) begin
                isWReg   <= isW;
                isRemReg <= remOp;
                qNegReg  <= signA ^ signB;
                rNegReg  <= signA;
                if (special) begin
                    resultReg <= specialResult;
                end else begin
                    remReg     <= '0;
                    quotReg    <= quotLoad;
                    divisorReg <= divisorLoad;
                end
            end

            if (state == CALC) begin
                remReg  <= remNext;
                quotReg <= quotNext;
            end

            if (state == FIX && !FlushE) resultReg <= fixResult;
        end
    end

    assign DivResultE = resultReg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomised scoreboard bench for div_seq_ctrl: a plain-arithmetic reference
// model supplies expected results and latencies; a monitor checks every DivDoneE.
module tb_div_seq_ctrl;
    import alu_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            enableE;
    logic [5:0]      ALUControlE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallDivE;
    logic            DivDoneE;
    logic [XLEN-1:0] DivResultE;

    div_seq_ctrl #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .enableE     (enableE),
        .ALUControlE (ALUControlE),
        .SrcAE       (SrcAE),
        .SrcBE       (SrcBE),
        .FlushE      (FlushE),
        .StallDivE   (StallDivE),
        .DivDoneE    (DivDoneE),
        .DivResultE  (DivResultE)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] result;
        int          latency;
        int          startCyc;
        string       name;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics written with language arithmetic.
    task automatic refModel(input logic [5:0] ctl, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] res, output bit special);
        logic [4:0]  op;
        bit          w, sgn, wantRem;
        logic [31:0] x, y, q32, r32, sel32;
        int          sx, sy;
        longint      sa, sb;
        logic [63:0] q64, r64;
        op      = ctl[4:0];
        w       = ctl[W_BIT];
        sgn     = (op == OP_DIV) || (op == OP_REM);
        wantRem = (op == OP_REM) || (op == OP_REMU);
        special = 1'b0;
        if (w) begin
            x = a[31:0];
            y = b[31:0];
            if (y == 0) begin
                q32 = 32'hFFFF_FFFF; r32 = x; special = 1'b1;
            end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q32 = x; r32 = 0; special = 1'b1;
            end else if (sgn) begin
                sx = x; sy = y;
                q32 = sx / sy; r32 = sx % sy;
            end else begin
                q32 = x / y; r32 = x % y;
            end
            sel32 = wantRem ? r32 : q32;
            res   = {{32{sel32[31]}}, sel32};
        end else begin
            if (b == 0) begin
                q64 = '1; r64 = a; special = 1'b1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q64 = a; r64 = 0; special = 1'b1;
            end else if (sgn) begin
                sa = a; sb = b;
                q64 = sa / sb; r64 = sa % sb;
            end else begin
                q64 = a / b; r64 = a % b;
            end
            res = wantRem ? r64 : q64;
        end
    endtask

    // Monitor: every DivDoneE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (DivDoneE === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got DivDoneE=1 result 0x%016h expected no pulse", DivResultE);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_result"}, DivResultE, e.result);
                check({e.name, "_latency"}, 64'(cyc - e.startCyc), 64'(e.latency));
            end
        end
    end

    task automatic runOp(input string name, input logic [5:0] ctl,
                         input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [63:0] res;
        bit          special, gotDone;
        int          stallCnt;
        @(posedge clk); #1;
        enableE = 1'b1; FlushE = 1'b0; ALUControlE = ctl; SrcAE = a; SrcBE = b;
        refModel(ctl, a, b, res, special);
        e.result   = res;
        e.latency  = special ? 1 : (ctl[W_BIT] ? 34 : 66);
        e.startCyc = cyc;
        e.name     = name;
        sbq.push_back(e);
        stallCnt = 0;
        gotDone  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (DivDoneE === 1'b1) begin
                gotDone = 1'b1;
                break;
            end
            if (StallDivE === 1'b1) stallCnt++;
            if (i >= 1) begin
                SrcAE = {$urandom, $urandom};
                SrcBE = {$urandom, $urandom};
            end
        end
        if (!gotDone) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no DivDoneE in 100 cycles expected one", name);
            void'(sbq.pop_back());
        end else begin
            check({name, "_stall_cycles"}, 64'(stallCnt), 64'(e.latency));
            check({name, "_stall_at_done"}, 64'(StallDivE), 64'd0);
        end
        @(posedge clk); #1;
        enableE = 1'b0;
    endtask

    function automatic logic [63:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return {$urandom, 32'h8000_0000};
            5:       return {$urandom, 32'hFFFF_FFFF};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] ops[4];
        int         doneSeen, stallSeen;
        ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;

        reset = 1'b1; enableE = 1'b0; FlushE = 1'b0;
        ALUControlE = '0; SrcAE = '0; SrcBE = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_stall", 64'(StallDivE), 64'd0);
        check("reset_done", 64'(DivDoneE), 64'd0);
        check("reset_result", DivResultE, 64'd0);

        runOp("div_100_7",     {1'b0, OP_DIV},  64'd100, 64'd7);
        runOp("rem_100_7",     {1'b0, OP_REM},  64'd100, 64'd7);
        runOp("div_m7_2",      {1'b0, OP_DIV},  -64'sd7, 64'd2);
        runOp("rem_m7_2",      {1'b0, OP_REM},  -64'sd7, 64'd2);
        runOp("remu_big_2",    {1'b0, OP_REMU}, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        runOp("divw_ovf",      {1'b1, OP_DIV},  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        runOp("remw_ovf",      {1'b1, OP_REM},  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        runOp("divu_by0",      {1'b0, OP_DIVU}, 64'd77, 64'd0);
        runOp("remu_by0",      {1'b0, OP_REMU}, 64'h1234, 64'd0);
        runOp("divuw_ffff_1",  {1'b1, OP_DIVU}, 64'h0000_0000_FFFF_FFFF, 64'd1);
        runOp("div_ovf64",     {1'b0, OP_DIV},  64'h8000_0000_0000_0000, '1);

        // Flush mid-iteration: stall drops next cycle and no result is produced.
        @(posedge clk); #1;
        enableE = 1'b1; ALUControlE = {1'b0, OP_DIV}; SrcAE = 64'd1000; SrcBE = 64'd3;
        repeat (10) @(posedge clk);
        #1 FlushE = 1'b1; enableE = 1'b0;
        @(posedge clk); #1 FlushE = 1'b0;
        @(negedge clk);
        check("flush_stall_next", 64'(StallDivE), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (DivDoneE === 1'b1) doneSeen++;
        end
        check("flush_no_done", 64'(doneSeen), 64'd0);
        runOp("divu_9_3", {1'b0, OP_DIVU}, 64'd9, 64'd3);

        // Reset mid-operation clears every output the following cycle.
        @(posedge clk); #1;
        enableE = 1'b1; ALUControlE = {1'b0, OP_REM}; SrcAE = 64'd12345; SrcBE = 64'd67;
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; enableE = 1'b0;
        @(negedge clk);
        check("midreset_stall", 64'(StallDivE), 64'd0);
        check("midreset_done", 64'(DivDoneE), 64'd0);
        check("midreset_result", DivResultE, 64'd0);

        // Non-divide ops must never stall or complete.
        stallSeen = 0; doneSeen = 0;
        foreach (ops[k]) begin
            @(posedge clk); #1;
            enableE = 1'b1; ALUControlE = {ops[k][0], 5'(k)}; SrcAE = 64'd5; SrcBE = 64'd0;
            repeat (4) begin
                @(negedge clk);
                if (StallDivE === 1'b1) stallSeen++;
                if (DivDoneE === 1'b1) doneSeen++;
            end
        end
        @(posedge clk); #1 enableE = 1'b0;
        check("nondiv_stall", 64'(stallSeen), 64'd0);
        check("nondiv_done", 64'(doneSeen), 64'd0);

        for (int n = 0; n < 24; n++) begin
            logic [5:0] ctl;
            ctl = {1'($urandom_range(0, 1)), ops[$urandom_range(0, 3)]};
            runOp($sformatf("rand%0d", n), ctl, pickOperand(), pickOperand());
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the integer divide/remainder ops (div, divu, rem, remu, divw, divuw, remw, remuw) in the Execute stage.
- Replaces the combinational single-cycle "/" and "%" path with a radix-2 restoring divider controlled by an FSM.
- Stalls the pipeline through the hazard unit while it iterates, then presents the result for one cycle so the pipeline can capture it into the M stage.

Parameters:
- XLEN, 64, datapath width; the W-variant width is fixed at 32.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enableE  in  1  E stage holds a valid instruction
- ALUControlE  in  6  op code; bit5 = W variant; [4:0] 6=div, 7=divu, 8=rem, 9=remu
- SrcAE  in  XLEN  dividend, already forwarded
- SrcBE  in  XLEN  divisor, already forwarded
- FlushE  in  1  kill the E-stage instruction
- StallDivE  out  1  to hazard unit: freeze F/D/E and bubble M
- DivDoneE  out  1  result valid this cycle
- DivResultE  out  XLEN  quotient or remainder; W results are sign-extended from bit 31

Behaviour:
- start = enableE & ~FlushE & ALUControlE[4:0] in {6,7,8,9}. Start is sampled only in IDLE.
- States and transitions:
  - IDLE: on start with a special case -> DONE; on start otherwise -> CALC (load operands); no start -> stay in IDLE.
  - CALC: N iterations, where N = 32 if W else XLEN. Count reaches N-1 -> FIX.
  - FIX: sign correction and quotient/remainder select -> DONE.
  - DONE: -> IDLE unconditionally. Start is ignored in DONE, because the E stage still holds the same instruction.
- Operand prep at load:
  - W ops use bits [31:0] only.
  - Signed ops (div, rem, divw, remw) take the magnitudes of the operands and record qneg = signA ^ signB and rneg = signA.
- Each iteration: rem = {rem, q_msb} - divisor if non-negative, else restore; shift the quotient bit in.
- FIX:
  - Quotient is negated if qneg; remainder is negated if rneg.
  - W results are sign-extended from bit 31. This applies to divuw/remuw too, per RISC-V.
- Special cases, which skip CALC (result registered in IDLE, available in DONE):
  - Divisor == 0: quotient = all ones (W: sign-extended 0xFFFFFFFF), remainder = dividend (W: sign-extended dividend[31:0]).
  - Signed overflow (dividend = most-negative, divisor = -1, 64-bit or 32-bit as applicable): quotient = dividend, remainder = 0.
- Timing (start sampled at cycle 0):
  - Normal op: CALC occupies cycles 1..N, FIX is cycle N+1, DONE is cycle N+2. Total latency is 66 for 64-bit and 34 for W.
  - Special case: DONE at cycle 1.
- StallDivE = (state == IDLE & start) | state in {CALC, FIX}. Stall is deasserted in DONE, so the pipeline advances and captures DivResultE at that edge.
- DivDoneE = 1 only in DONE. DivResultE is valid only when DivDoneE = 1, and holds its last value otherwise.
- FlushE in any state: next state is IDLE, no DONE pulse, and StallDivE drops in the following cycle.
- reset: state = IDLE, counter = 0, StallDivE = 0, DivDoneE = 0, DivResultE = 0, all internal registers = 0. Reset mid-operation aborts it the same way.
- Non-divide ops never assert StallDivE or DivDoneE.
- Operand inputs are not required to be stable after cycle 0; they are latched at start.

Decomposition:
- alu_pkg:
  - ALU op code constants (OP_DIV = 6, OP_DIVU = 7, OP_REM = 8, OP_REMU = 9, W_BIT = 5).
  - div_state_t enum {IDLE, CALC, FIX, DONE}.
- One sub-module, div_iter_step: the combinational single restoring step (rem_in, quot_in, divisor) -> (rem_out, quot_out), parameterised by XLEN.
- The FSM, counter, sign handling and special-case detection stay in div_seq_ctrl.

Test Plan:
- div, A = 100, B = 7 -> StallDivE high in cycles 0..65, DivDoneE at cycle 66, DivResultE = 14. Same operands with rem -> 2.
- div, A = -7, B = 2 -> -3 (0xFFFF_FFFF_FFFF_FFFD). rem with the same operands -> -1. remu, A = 0xFFFF_FFFF_FFFF_FFF9, B = 2 -> 1.
- divw, A = 0x0000_0000_8000_0000, B = 0xFFFF_FFFF -> overflow, DONE at cycle 1, result 0xFFFF_FFFF_8000_0000. remw with the same operands -> 0.
- divu, B = 0 -> DONE at cycle 1, result all ones. remu, A = 0x1234, B = 0 -> 0x1234.
- divuw, A = 0xFFFF_FFFF, B = 1 -> DONE at cycle 34, result 0xFFFF_FFFF_FFFF_FFFF (sign-extended).
- div started, FlushE asserted at cycle 10 -> IDLE at cycle 11, no DivDoneE. A new divu, A = 9, B = 3, then completes with result 3. Reset asserted at cycle 20 of another op -> all outputs 0 next cycle.
